uart_rx_fifo: RTL and testbench

- Receive front-end for the MiST UART_RXD pin.
- Synchronises and filters the asynchronous serial line, then decodes 8N1 frames using 16x oversampling.
- Queues received bytes in a small FIFO that the SVI328 guest's serial-port logic drains with a valid/ready handshake.
- Sits between the top-level UART_RXD pad and the guest's I/O register block.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_fifo_sync_fifo.sv | 55 +++++
 rtl/uart_rx_fifo.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    localparam int unsigned OVERSAMPLE = 16;

    // round(OVERSAMPLE * baud * 2^24 / clk_hz) for a 24-bit phase accumulator.
    function automatic logic [23:0] baud_inc(input longint unsigned clk_hz,
                                             input longint unsigned baud);
        longint unsigned num;
        num = 64'(OVERSAMPLE) * baud * (64'd1 << 24);
        return 24'((num + clk_hz / 2) / clk_hz);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted only when a pop retires the head in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = DEPTH[DEPTH_LOG2:0];

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  do_push;
    logic                  do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_COUNT);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // When full, wr_ptr == rd_ptr: the incoming byte overwrites the slot being popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with 16x oversampling, majority filtering and a byte FIFO drained by valid/ready.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 42660000,
    parameter int unsigned BAUD            = 115200,
    parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       err_clr,
    output logic       rx_busy
);

    localparam logic [23:0] INC       = baud_inc(64'(CLK_HZ), 64'(BAUD));
    localparam logic [3:0]  LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]  MID_TICK  = 4'(OVERSAMPLE / 2 - 1);

    logic [23:0] acc;
    logic [24:0] acc_sum;
    logic        tick;
    logic        sync1;
    logic        sync2;
    logic [2:0]  samp;
    logic        line;

    rx_state_t   state;
    rx_state_t   state_nx;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nx;
    logic [2:0]  bit_idx;
    logic [2:0]  bit_idx_nx;
    logic [7:0]  shreg;
    logic [7:0]  shreg_nx;
    logic        push;
    logic        frame_set;
    logic        overrun_set;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;

    assign acc_sum = {1'b0, acc} + {1'b0, INC};
    assign tick    = acc_sum[24];
    assign line    = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            samp  <= '1;
        end else begin
            acc   <= acc_sum[23:0];
            sync1 <= rxd;
            sync2 <= sync1;
            if (tick) begin
                samp <= {samp[1:0], sync2};
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_idx <= bit_idx_nx;
            shreg   <= shreg_nx;
        end
    end

    // The stop sample returns straight to IDLE so a back-to-back start is caught on the next tick.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        bit_idx_nx = bit_idx;
        shreg_nx   = shreg;
        push       = 1'b0;
        frame_set  = 1'b0;
        if (tick) begin
            unique case (state)
                IDLE: begin
                    if (!line) begin
                        state_nx = START;
                        cnt_nx   = '0;
                    end
                end
                START: begin
                    if (cnt == MID_TICK) begin
                        cnt_nx     = '0;
                        bit_idx_nx = '0;
                        state_nx   = line ? IDLE : DATA;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == LAST_TICK) begin
                        cnt_nx     = '0;
                        shreg_nx   = {line, shreg[7:1]};
                        bit_idx_nx = bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state_nx = STOP;
                        end
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == LAST_TICK) begin
                        cnt_nx    = '0;
                        state_nx  = IDLE;
                        push      = line;
                        frame_set = !line;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign rx_busy     = (state != IDLE);
    assign rx_valid    = !fifo_empty;
    assign pop         = rx_ready && rx_valid;
    assign overrun_set = push && fifo_full && !pop;

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk_sys),
        .rst       (reset),
        .push      (push),
        .push_data (shreg),
        .pop       (pop),
        .pop_data  (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_set) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue/flag model checked every cycle, stop-sample timing derived from the accumulator rule.
module tb_uart_rx_fifo;

    localparam int unsigned CLK_HZ = 42660000;
    localparam int unsigned BAUD   = 115200;
    // round(16 * 115200 * 2^24 / 42660000) = round(724888.995), worked by hand.
    localparam longint unsigned INC = 724889;
    localparam int BIT_CYC = 370;

    logic       clk_sys  = 1'b0;
    logic       reset    = 1'b0;
    logic       rxd      = 1'b1;
    logic       rx_ready = 1'b0;
    logic       err_clr  = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    uart_rx_fifo #(
        .CLK_HZ          (CLK_HZ),
        .BAUD            (BAUD),
        .FIFO_DEPTH_LOG2 (2)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr),
        .rx_busy   (rx_busy)
    );

    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] q[$];
    logic       m_ferr = 1'b0;
    logic       m_ovr  = 1'b0;
    bit         chk_en = 1'b0;

    // Clock edges since reset release; edge k carries a tick iff floor(k*INC/2^24) advances.
    longint unsigned edge_cnt;
    always @(posedge clk_sys or posedge reset) begin
        if (reset) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic longint unsigned ticks(input longint unsigned k);
        return (k * INC) >> 24;
    endfunction

    function automatic longint unsigned find_edge(input longint unsigned from, input longint unsigned n);
        longint unsigned target;
        longint unsigned k;
        target = ticks(from) + n;
        k = from;
        while (ticks(k) < target) k++;
        return k;
    endfunction

    always @(negedge clk_sys) begin
        if (chk_en) begin
            logic [10:0] act;
            logic [10:0] exp;
            act = {rx_valid, rx_valid ? rx_data : 8'h00, frame_err, overrun};
            exp = {q.size() != 0, q.size() != 0 ? q[0] : 8'h00, m_ferr, m_ovr};
            check("model", act, exp);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic wait_busy(input int limit, output longint unsigned kd, output bit ok);
        ok = 1'b0;
        kd = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_sys);
            if (rx_busy) begin
                ok = 1'b1;
                kd = edge_cnt;
                return;
            end
        end
    endtask

    task automatic wait_neg(input longint unsigned k);
        int guard;
        guard = 0;
        while (edge_cnt < k && guard < 10000) begin
            @(negedge clk_sys);
            guard++;
        end
        if (edge_cnt != k) begin
            n_cmp++;
            n_bad++;
            $display("FAIL edge_wait: reached edge %0d required %0d", edge_cnt, k);
        end
    endtask

    // A start that must be rejected at mid-bit: busy holds for exactly 8 ticks.
    task automatic expect_false_start(input string name, input int limit);
        longint unsigned kd;
        longint unsigned pd;
        bit ok;
        wait_busy(limit, kd, ok);
        check({name, "_busy_rise"}, ok, 1);
        if (ok) begin
            pd = find_edge(kd, 8);
            wait_neg(pd - 1);
            check({name, "_busy_hold"}, rx_busy, 1);
            wait_neg(pd);
            check({name, "_busy_fall"}, rx_busy, 0);
        end
    endtask

    task automatic run_frame(input logic [7:0] b, input bit stop_ok, input bit pop_at_push);
        longint unsigned k_start;
        rxd = 1'b0;
        k_start = edge_cnt;
        fork
            begin
                repeat (BIT_CYC) @(negedge clk_sys);
                for (int i = 0; i < 8; i++) begin
                    rxd = b[i];
                    repeat (BIT_CYC) @(negedge clk_sys);
                end
                rxd = stop_ok;
                repeat (BIT_CYC) @(negedge clk_sys);
                rxd = 1'b1;
            end
            begin
                longint unsigned kd;
                longint unsigned p;
                bit ok;
                wait_busy(200, kd, ok);
                check("frame_busy_rise", ok, 1);
                if (ok) begin
                    // 8 ticks to mid-start, 8 x 16 data ticks, 16 more to the stop sample.
                    p = find_edge(kd, 152);
                    check("stop_latency", (p - k_start >= 9 * BIT_CYC) && (p - k_start < 10 * BIT_CYC), 1);
                    wait_neg(p - 1);
                    check("busy_at_stop", rx_busy, 1);
                    if (pop_at_push) rx_ready = 1'b1;
                    @(posedge clk_sys);
                    #1;
                    rx_ready = 1'b0;
                    if (pop_at_push && q.size() != 0) void'(q.pop_front());
                    if (!stop_ok)          m_ferr = 1'b1;
                    else if (q.size() < 4) q.push_back(b);
                    else                   m_ovr = 1'b1;
                    @(negedge clk_sys);
                    check("busy_after_stop", rx_busy, 0);
                    if (!stop_ok) expect_false_start("stop_low_tail", 150);
                end
            end
        join
    endtask

    task automatic pop_seq(input int n, input logic [31:0] exp_bytes);
        for (int i = 0; i < n; i++) begin
            check("pop_data", rx_data, exp_bytes[8*i +: 8]);
            rx_ready = 1'b1;
            @(posedge clk_sys);
            #1;
            if (q.size() != 0) void'(q.pop_front());
            @(negedge clk_sys);
        end
        rx_ready = 1'b0;
    endtask

    task automatic err_pulse();
        err_clr = 1'b1;
        @(posedge clk_sys);
        #1;
        err_clr = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        @(negedge clk_sys);
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (3) @(negedge clk_sys);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_rx_busy", rx_busy, 0);
        reset = 1'b0;
        chk_en = 1'b1;
        idle(20);

        run_frame(8'h55, 1'b1, 1'b0);
        idle(50);
        check("single_valid", rx_valid, 1);
        check("single_data", rx_data, 8'h55);
        check("single_ferr", frame_err, 0);
        pop_seq(1, 32'h0000_0055);
        check("single_drained", rx_valid, 0);

        run_frame(8'h01, 1'b1, 1'b0);
        run_frame(8'h80, 1'b1, 1'b0);
        run_frame(8'hFF, 1'b1, 1'b0);
        run_frame(8'h3C, 1'b1, 1'b0);
        run_frame(8'hAA, 1'b1, 1'b0);
        idle(50);
        check("ovr_set", overrun, 1);
        pop_seq(4, 32'h3CFF_8001);
        check("ovr_drained", rx_valid, 0);
        err_pulse();
        check("ovr_cleared", overrun, 0);

        run_frame(8'hA5, 1'b0, 1'b0);
        idle(100);
        check("ferr_set", frame_err, 1);
        check("ferr_no_push", rx_valid, 0);
        err_pulse();
        check("ferr_cleared", frame_err, 0);

        rxd = 1'b0;
        fork
            begin
                repeat (69) @(negedge clk_sys);
                rxd = 1'b1;
            end
            expect_false_start("glitch", 150);
        join
        idle(100);
        check("glitch_no_push", rx_valid, 0);
        check("glitch_no_ferr", frame_err, 0);

        run_frame(8'h12, 1'b1, 1'b0);
        run_frame(8'h34, 1'b1, 1'b0);
        idle(50);
        check("pre_reset_valid", rx_valid, 1);
        rxd = 1'b0;
        repeat (BIT_CYC * 9 / 2) @(negedge clk_sys);
        check("mid_frame_busy", rx_busy, 1);
        chk_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("arst_rx_data", rx_data, 8'h00);
        check("arst_rx_valid", rx_valid, 0);
        check("arst_frame_err", frame_err, 0);
        check("arst_overrun", overrun, 0);
        check("arst_rx_busy", rx_busy, 0);
        q.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        rxd = 1'b1;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        chk_en = 1'b1;
        idle(2 * BIT_CYC);
        run_frame(8'h3C, 1'b1, 1'b0);
        idle(50);
        check("post_reset_data", rx_data, 8'h3C);
        pop_seq(1, 32'h0000_003C);

        run_frame(8'h11, 1'b1, 1'b0);
        run_frame(8'h22, 1'b1, 1'b0);
        run_frame(8'h33, 1'b1, 1'b0);
        run_frame(8'h44, 1'b1, 1'b0);
        run_frame(8'h5A, 1'b1, 1'b1);
        idle(20);
        check("full_swap_no_ovr", overrun, 0);
        check("full_swap_head", rx_data, 8'h22);
        pop_seq(4, 32'h5A44_3322);
        check("full_swap_drained", rx_valid, 0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        n_bad++;
        $display("FAIL watchdog: run still active at %0t, required completion", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
